// File: rtl/clock_display_scan_pkg.sv
// Shared constants and types for the clock display scanner.
// Segment codes are active-low {g,f,e,d,c,b,a}.
package clock_display_pkg;

  localparam int NUM_DIGITS = 6;

  typedef logic [2:0] digit_idx_t;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  localparam logic [0:9][6:0] SEG_LUT = {
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  localparam digit_idx_t SEP_MIN_IDX  = 3'd2;
  localparam digit_idx_t SEP_HOUR_IDX = 3'd4;

endpackage

// File: rtl/clock_display_scan_if.sv
// Time fields in, multiplexed seven-segment drive out.
interface clock_display_scan_if;

  logic [5:0] second;
  logic [5:0] min;
  logic [5:0] hour;
  logic [6:0] seg_n;
  logic       dp_n;
  logic [5:0] an_n;
  logic       frame_start;

  modport master (
    output second, min, hour,
    input  seg_n, dp_n, an_n, frame_start
  );

  modport slave (
    input  second, min, hour,
    output seg_n, dp_n, an_n, frame_start
  );

endinterface

// File: rtl/clock_display_scan_seven_seg_encode.sv
// BCD digit to active-low seven-segment code; dash overrides blank.
module seven_seg_encode
  import clock_display_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  input  logic       dash,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    if (dash)
      seg = SEG_DASH;
    else if (blank)
      seg = SEG_BLANK;
    else if (digit <= 4'd9)
      seg = SEG_LUT[digit];
  end

endmodule

// File: rtl/clock_display_scan.sv
// Six-digit HH.MM.SS multiplexed display driver with per-frame snapshot and anode guard.
// Define HOUR_LZB_EN to blank a leading zero in the hours tens digit.
module clock_display_scan
  import clock_display_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic                 clk,
  input  logic                 reset,
  clock_display_scan_if.slave  bus
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PC_MAX = PW'(SCAN_DIV - 1);
  localparam digit_idx_t IDX_MAX = digit_idx_t'(NUM_DIGITS - 1);

  logic [PW-1:0] pc;
  digit_idx_t    idx;
  logic [5:0]    snap_s, snap_m, snap_h;

  logic          slot_end, frame_wrap;
  logic [5:0]    val;
  logic [3:0]    tens, ones, digit;
  logic          dash, blank, dp;
  logic [6:0]    seg;

  assign slot_end   = (pc == PC_MAX);
  assign frame_wrap = slot_end && (idx == IDX_MAX);

  // Digit pairs: idx[2:1] picks the field, idx[0] picks tens over ones.
  always_comb begin
    val   = snap_s;
    dash  = 1'b0;
    blank = 1'b0;
    case (idx[2:1])
      2'd0:    val = snap_s;
      2'd1:    val = snap_m;
      default: val = snap_h;
    endcase
    tens  = 4'(val / 6'd10);
    ones  = 4'(val % 6'd10);
    digit = idx[0] ? tens : ones;
    if (idx[2:1] == 2'd2)
      dash = (val > 6'd23);
    else
      dash = (val > 6'd59);
`ifdef HOUR_LZB_EN
    blank = (idx == IDX_MAX) && (tens == 4'd0);
`else
    blank = 1'b0;
`endif
    dp = (idx == SEP_MIN_IDX) || (idx == SEP_HOUR_IDX);
  end

  seven_seg_encode u_enc (
    .digit (digit),
    .blank (blank),
    .dash  (dash),
    .seg   (seg)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      pc              <= '0;
      idx             <= '0;
      snap_s          <= '0;
      snap_m          <= '0;
      snap_h          <= '0;
      bus.seg_n       <= SEG_BLANK;
      bus.dp_n        <= 1'b1;
      bus.an_n        <= '1;
      bus.frame_start <= 1'b0;
    end else begin
      pc <= slot_end ? '0 : pc + 1'b1;
      if (slot_end)
        idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
      if (frame_wrap) begin
        snap_s <= bus.second;
        snap_m <= bus.min;
        snap_h <= bus.hour;
      end
      bus.frame_start <= frame_wrap;
      bus.seg_n       <= seg;
      bus.dp_n        <= ~dp;
      // First cycle of each slot keeps every anode off to hide the segment change.
      bus.an_n        <= (pc == '0) ? '1 : ~(6'(1) << idx);
    end
  end

endmodule
